// File: rtl/full_hk_pkg.sv
// full_hk_pkg
// Shared types and helpers for the multi-channel full-handshake transmitter.
//   hk_state_t      : handshake FSM state (IDLE, REQ, REL)
//   ch_w()          : width of a channel index for a given channel count
//   TIMEOUT_DEFAULT : default ack wait limit in cycles
package full_hk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } hk_state_t;

  localparam int TIMEOUT_DEFAULT = 64;

  // Index width for n channels; never below 1 so ports stay legal.
  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_hk_rr_arb.sv
// full_hk_rr_arb
// Round-robin arbiter. The search starts at ptr and wraps modulo NUM_CH;
// the first requesting channel wins.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   req      : request vector (one bit per channel)
//   ptr      : current round-robin start index
//   gnt_en   : a grant is taken at this edge (advances the pointer)
//   gnt_oh   : combinational one-hot grant
//   gnt_idx  : combinational binary index of the grant
//   ptr_nxt  : registered pointer, grant+1 wrapping to 0 after each grant
module full_hk_rr_arb
  import full_hk_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              gnt_en,
  output logic [NUM_CH-1:0] gnt_oh,
  output logic [CH_W-1:0]   gnt_idx,
  output logic [CH_W-1:0]   ptr_nxt
);

  logic found;

  always_comb begin
    int j;
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!found && req[j]) begin
        found     = 1'b1;
        gnt_oh[j] = 1'b1;
        gnt_idx   = CH_W'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_nxt <= '0;
    end else if (gnt_en && found) begin
      ptr_nxt <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/full_hk_mc_tx.sv
// full_hk_mc_tx
// Multi-channel four-phase (full) handshake transmitter. Single-cycle
// requests from NUM_CH producers land in one-deep pending slots; a
// round-robin arbiter picks one slot at a time and the FSM runs a
// wr_vld/rd_ack handshake carrying its payload and channel ID.
// Optional feature macro: FULL_HK_TIMEOUT_EN (ack wait limit, err pulse).
// Handshake: wr_vld rises with wr_data/wr_ch stable; it stays high until
// rd_ack=1 is sampled, then falls; the cycle ends once rd_ack=0 is sampled
// (done pulses). wr_data/wr_ch hold until the next grant.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   ch_vld    : per-channel one-cycle request strobe
//   ch_data   : per-channel payload, sampled with ch_vld
//   ch_busy   : per-channel pending slot occupied
//   ch_drop   : per-channel one-cycle pulse on a rejected request
//   wr_vld    : handshake request to the consumer
//   wr_data   : payload of the granted channel
//   wr_ch     : channel ID of the payload
//   rd_ack    : consumer acknowledge (same clock domain)
//   done      : one-cycle pulse when a handshake completes
//   err       : one-cycle pulse on timeout (0 without the macro)
//   dbg_state : current FSM state
module full_hk_mc_tx
  import full_hk_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_vld,
  input  logic [NUM_CH-1:0][DW-1:0]  ch_data,
  output logic [NUM_CH-1:0]          ch_busy,
  output logic [NUM_CH-1:0]          ch_drop,
  output logic                       wr_vld,
  output logic [DW-1:0]              wr_data,
  output logic [CH_W-1:0]            wr_ch,
  input  logic                       rd_ack,
  output logic                       done,
  output logic                       err,
  output hk_state_t                  dbg_state
);

  hk_state_t                 state, state_nxt;
  logic [NUM_CH-1:0]         slot_vld;
  logic [NUM_CH-1:0][DW-1:0] slot_data;
  logic [NUM_CH-1:0]         gnt_oh;
  logic [CH_W-1:0]           gnt_idx;
  logic [CH_W-1:0]           rr_ptr;
  logic                      grant;
  logic                      to_hit;   // wait limit reached this cycle
  logic                      to_flag;  // REL entered by a REQ timeout

  assign grant     = (state == ST_IDLE) && (|slot_vld);
  assign ch_busy   = slot_vld;
  assign dbg_state = state;

  full_hk_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (slot_vld),
    .ptr     (rr_ptr),
    .gnt_en  (grant),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .ptr_nxt (rr_ptr)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state; ack takes priority over the wait limit
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|slot_vld) state_nxt = ST_REQ;
      ST_REQ:  if (rd_ack || to_hit) state_nxt = ST_REL;
      ST_REL:  if (!rd_ack || to_hit) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pending slots, drop pulses and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld  <= '0;
      slot_data <= '0;
      ch_drop   <= '0;
      wr_vld    <= 1'b0;
      wr_data   <= '0;
      wr_ch     <= '0;
      done      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // A request on the channel being granted reloads its slot.
        if (ch_vld[i] && (!slot_vld[i] || (grant && gnt_oh[i]))) begin
          slot_vld[i]  <= 1'b1;
          slot_data[i] <= ch_data[i];
        end else if (grant && gnt_oh[i]) begin
          slot_vld[i]  <= 1'b0;
        end
        ch_drop[i] <= ch_vld[i] && slot_vld[i] && !(grant && gnt_oh[i]);
      end
      if (grant) begin
        wr_data <= slot_data[gnt_idx];
        wr_ch   <= gnt_idx;
      end
      wr_vld <= (state_nxt == ST_REQ);
      done   <= (state == ST_REL) && !rd_ack && !to_flag;
    end
  end

`ifdef FULL_HK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] wait_cnt;

  assign to_hit = (state != ST_IDLE) && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || (state_nxt != state)) wait_cnt <= '0;
    else if (state != ST_IDLE)       wait_cnt <= wait_cnt + 1'b1;
  end

  // After a REQ timeout, done is only reported if ack is later seen high
  // and then returns low.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_flag <= 1'b0;
    end else if ((state == ST_REQ) && !rd_ack && to_hit) begin
      to_flag <= 1'b1;
    end else if ((state_nxt == ST_IDLE) || ((state == ST_REL) && rd_ack)) begin
      to_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= to_hit && (((state == ST_REQ) && !rd_ack) ||
                               ((state == ST_REL) && rd_ack));
  end
`else
  assign to_hit  = 1'b0;
  assign to_flag = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_full_hk_mc_tx.sv
// tb_full_hk_mc_tx
// Directed bench for full_hk_mc_tx. Expected {wr_ch, wr_data} pairs are
// queued when requests are driven and popped on each wr_vld rising edge.
// Define FULL_HK_TIMEOUT_EN for both files to include the timeout steps.
module tb_full_hk_mc_tx;
  import full_hk_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int CH_W   = 2;
  localparam int TOUT   = 8;
  localparam int W      = CH_W + DW;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_CH-1:0]         ch_vld;
  logic [NUM_CH-1:0][DW-1:0] ch_data;
  logic [NUM_CH-1:0]         ch_busy;
  logic [NUM_CH-1:0]         ch_drop;
  logic                      wr_vld;
  logic [DW-1:0]             wr_data;
  logic [CH_W-1:0]           wr_ch;
  logic                      rd_ack;
  logic                      done;
  logic                      err;
  hk_state_t                 dbg_state;

  logic auto_ack;
  logic man_ack;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int drop1_cnt = 0;
  logic [W-1:0] exp_q[$];

  full_hk_mc_tx #(.NUM_CH(NUM_CH), .DW(DW), .TIMEOUT(TOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_vld    (ch_vld),
    .ch_data   (ch_data),
    .ch_busy   (ch_busy),
    .ch_drop   (ch_drop),
    .wr_vld    (wr_vld),
    .wr_data   (wr_data),
    .wr_ch     (wr_ch),
    .rd_ack    (rd_ack),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // consumer: either follows wr_vld after one register stage or holds man_ack
  always @(posedge clk) rd_ack <= auto_ack ? wr_vld : man_ack;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard / monitor on the falling edge
  initial begin
    logic         prev_vld;
    logic [W-1:0] held;
    logic [W-1:0] e;
    prev_vld = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (wr_vld === 1'b1 && prev_vld !== 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        chk("grant_ch_data", {wr_ch, wr_data}, e);
      end else if (wr_vld === 1'b1 && prev_vld === 1'b1) begin
        chk("hold_stable", {wr_ch, wr_data}, held);
      end
      if (wr_vld === 1'b1) held = {wr_ch, wr_data};
      prev_vld = wr_vld;
      if (done === 1'b1)       done_cnt++;
      if (err === 1'b1)        err_cnt++;
      if (ch_drop[1] === 1'b1) drop1_cnt++;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int ch, input logic [DW-1:0] d);
    ch_vld[ch]  = 1'b1;
    ch_data[ch] = d;
    step(1);
    ch_vld[ch]  = 1'b0;
  endtask

  task automatic wait_vld(output int cyc);
    cyc = 0;
    while (wr_vld !== 1'b1 && cyc < 30) begin
      step(1);
      cyc++;
    end
    chk("vld_rise_seen", {31'd0, wr_vld}, 32'd1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while (done !== 1'b1 && cyc < 60);
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int c;
    int d0;
    int e0;
    rst = 1'b1; ch_vld = '0; ch_data = '0; auto_ack = 1'b1; man_ack = 1'b0;
    step(3);
    chk("rst_wr_vld",  {31'd0, wr_vld}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_wr_ch",   {30'd0, wr_ch}, 32'd0);
    chk("rst_busy",    {28'd0, ch_busy}, 32'd0);
    chk("rst_drop",    {28'd0, ch_drop}, 32'd0);
    chk("rst_done",    {31'd0, done}, 32'd0);
    chk("rst_err",     {31'd0, err}, 32'd0);
    chk("rst_state",   {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rst = 1'b0;
    step(1);

    // single transfer on ch2
    exp_q.push_back({2'd2, 8'hA5});
    pulse(2, 8'hA5);
    chk("t1_busy_set", {28'd0, ch_busy}, 32'h4);
    chk("t1_vld_low",  {31'd0, wr_vld}, 32'd0);
    wait_vld(c);
    chk("t1_grant_lat", c, 32'd1);
    chk("t1_busy_clr", {28'd0, ch_busy}, 32'h0);
    d0 = done_cnt;
    wait_done(c);
    chk("t1_done_lat", c, 32'd4);
    step(1);
    chk("t1_done_width", {31'd0, done}, 32'd0);
    chk("t1_done_once",  done_cnt, d0 + 1);

    // all channels at once, pointer at 3: order 3,0,1,2
    for (int i = 0; i < NUM_CH; i++) ch_data[i] = 8'h10 + 8'(i);
    exp_q.push_back({2'd3, 8'h13});
    exp_q.push_back({2'd0, 8'h10});
    exp_q.push_back({2'd1, 8'h11});
    exp_q.push_back({2'd2, 8'h12});
    ch_vld = 4'hF;
    step(1);
    ch_vld = 4'h0;
    chk("t2_all_busy", {28'd0, ch_busy}, 32'hF);
    for (int i = 0; i < NUM_CH; i++) wait_done(c);
    chk("t2_sb_empty", exp_q.size(), 32'd0);

    // drop while busy, then recapture on the grant edge
    auto_ack = 1'b0; man_ack = 1'b0;
    exp_q.push_back({2'd0, 8'h20});
    pulse(0, 8'h20);
    exp_q.push_back({2'd1, 8'h31});
    pulse(1, 8'h31);
    pulse(1, 8'h32);
    chk("t3_drop_once", drop1_cnt, 32'd1);
    chk("t3_busy_ch1",  {28'd0, ch_busy}, 32'h2);
    chk("t3_in_req_ch", {30'd0, wr_ch}, 32'd0);
    auto_ack = 1'b1;
    wait_done(c);
    exp_q.push_back({2'd1, 8'h34});
    ch_vld[1] = 1'b1; ch_data[1] = 8'h34;
    step(1);
    ch_vld[1] = 1'b0;
    chk("t3_recap_busy", {31'd0, ch_busy[1]}, 32'd1);
    chk("t3_recap_ch",   {30'd0, wr_ch}, 32'd1);
    chk("t3_recap_data", {24'd0, wr_data}, 32'h31);
    chk("t3_no_drop",    drop1_cnt, 32'd1);
    wait_done(c);
    wait_done(c);
    chk("t3_sb_empty", exp_q.size(), 32'd0);

    // slow consumer
    auto_ack = 1'b0; man_ack = 1'b0;
    exp_q.push_back({2'd3, 8'h5C});
    pulse(3, 8'h5C);
    wait_vld(c);
    d0 = done_cnt;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("t4_vld_held",  {31'd0, wr_vld}, 32'd1);
      chk("t4_data_held", {24'd0, wr_data}, 32'h5C);
    end
    chk("t4_no_done", done_cnt, d0);
    auto_ack = 1'b1;
    wait_done(c);

    // reset while in REQ; pointer must return to 0
    auto_ack = 1'b0; man_ack = 1'b0;
    exp_q.push_back({2'd0, 8'h66});
    pulse(0, 8'h66);
    pulse(2, 8'h77);
    chk("t5_in_req",   {31'd0, wr_vld}, 32'd1);
    chk("t5_pending2", {28'd0, ch_busy}, 32'h4);
    d0 = done_cnt;
    rst = 1'b1;
    step(1);
    chk("t5_rst_vld",   {31'd0, wr_vld}, 32'd0);
    chk("t5_rst_busy",  {28'd0, ch_busy}, 32'h0);
    chk("t5_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    step(1);
    rst = 1'b0;
    auto_ack = 1'b1;
    step(1);
    chk("t5_no_done", done_cnt, d0);
    exp_q.push_back({2'd0, 8'h80});
    exp_q.push_back({2'd1, 8'h81});
    ch_data[0] = 8'h80; ch_data[1] = 8'h81;
    ch_vld = 4'h3;
    step(1);
    ch_vld = 4'h0;
    wait_done(c);
    wait_done(c);
    chk("t5_sb_empty", exp_q.size(), 32'd0);

`ifdef FULL_HK_TIMEOUT_EN
    // ack never arrives: err after TOUT cycles, no done
    auto_ack = 1'b0; man_ack = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    exp_q.push_back({2'd3, 8'h99});
    pulse(3, 8'h99);
    wait_vld(c);
    c = 0;
    while (err !== 1'b1 && c < 20) begin
      step(1);
      c++;
    end
    chk("t6_err_lat", c, TOUT);
    chk("t6_vld_low", {31'd0, wr_vld}, 32'd0);
    step(3);
    chk("t6_no_done",  done_cnt, d0);
    chk("t6_err_once", err_cnt, e0 + 1);
    chk("t6_idle",     {30'd0, dbg_state}, {30'd0, ST_IDLE});
    auto_ack = 1'b1;
`else
    e0 = 0;
    chk("no_err_pulses", err_cnt, e0);
`endif

    step(2);
    chk("final_sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
